// File: rtl/xif_offload_master.sv
// Offload master: issues one core instruction at a time to a coprocessor,
// relays the core's commit decision, and routes results (in any order) back
// to the core writeback port while tracking outstanding IDs.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a new core request when an ID slot is free
// S_ISSUE  | issue request presented to the coprocessor, held until ready
// S_COMMIT | waiting for the core commit/kill decision on the issued op
module xif_offload_master #(
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [31:0]         req_instr_i,
   input  logic [31:0]         req_rs1_i,
   input  logic [31:0]         req_rs2_i,
   output logic                x_issue_valid_o,
   input  logic                x_issue_ready_i,
   output logic [31:0]         x_issue_instr_o,
   output logic [31:0]         x_issue_rs1_o,
   output logic [31:0]         x_issue_rs2_o,
   output logic [ID_WIDTH-1:0] x_issue_id_o,
   input  logic                x_issue_accept_i,
   input  logic                x_issue_writeback_i,
   input  logic                commit_valid_i,
   input  logic                commit_kill_i,
   output logic                x_commit_valid_o,
   output logic [ID_WIDTH-1:0] x_commit_id_o,
   output logic                x_commit_kill_o,
   input  logic                x_result_valid_i,
   output logic                x_result_ready_o,
   input  logic [ID_WIDTH-1:0] x_result_id_i,
   input  logic [4:0]          x_result_rd_i,
   input  logic [31:0]         x_result_data_i,
   input  logic                x_result_we_i,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   output logic [4:0]          wb_rd_o,
   output logic [31:0]         wb_data_o,
   output logic [ID_WIDTH-1:0] wb_id_o,
   output logic                illegal_o,
   output logic                err_o
);

   localparam int NUM_IDS = 2 ** ID_WIDTH;
   localparam logic [ID_WIDTH:0] MAX_CNT = (ID_WIDTH + 1)'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMMIT} state_e;

   state_e                state_q, state_d;
   logic [ID_WIDTH-1:0]   next_id_q, next_id_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [31:0]           instr_q, instr_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic                  accepted_q, accepted_d;
   logic                  illegal_q, illegal_d;
   logic                  commit_valid_q, commit_valid_d;
   logic [ID_WIDTH-1:0]   commit_id_q, commit_id_d;
   logic                  commit_kill_q, commit_kill_d;
   logic [NUM_IDS-1:0]    pending_q, pending_d;
   logic                  wb_valid_q, wb_valid_d;
   logic [4:0]            wb_rd_q, wb_rd_d;
   logic [31:0]           wb_data_q, wb_data_d;
   logic [ID_WIDTH-1:0]   wb_id_q, wb_id_d;
   logic                  err_q, err_d;
   logic [ID_WIDTH:0]     pend_cnt;
   logic                  req_ready;
   logic                  res_hs;

   // Number of IDs awaiting a result.
   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         pend_cnt = pend_cnt + {{ID_WIDTH{1'b0}}, pending_q[i]};
      end
   end

   assign req_ready = (state_q == S_IDLE) && !rst_i && (pend_cnt < MAX_CNT) &&
                      !pending_q[next_id_q];
   assign res_hs    = x_result_valid_i && x_result_ready_o;

   // Next-state, pending-table and writeback logic.
   always_comb begin
      state_d        = state_q;
      next_id_d      = next_id_q;
      id_d           = id_q;
      instr_d        = instr_q;
      rs1_d          = rs1_q;
      rs2_d          = rs2_q;
      accepted_d     = accepted_q;
      illegal_d      = 1'b0;
      commit_valid_d = 1'b0;
      commit_id_d    = commit_id_q;
      commit_kill_d  = 1'b0;
      pending_d      = pending_q;
      wb_valid_d     = wb_valid_q;
      wb_rd_d        = wb_rd_q;
      wb_data_d      = wb_data_q;
      wb_id_d        = wb_id_q;
      err_d          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i && req_ready) begin
               instr_d = req_instr_i;
               rs1_d   = req_rs1_i;
               rs2_d   = req_rs2_i;
               id_d    = next_id_q;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (x_issue_ready_i) begin
               if (x_issue_accept_i && x_issue_writeback_i) pending_d[id_q] = 1'b1;
               illegal_d  = !x_issue_accept_i;
               accepted_d = x_issue_accept_i;
               next_id_d  = next_id_q + 1'b1;
               state_d    = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (commit_valid_i) begin
               commit_valid_d = 1'b1;
               commit_id_d    = id_q;
               commit_kill_d  = commit_kill_i || !accepted_q;
               state_d        = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A killed op will never get a usable result, so free its slot now.
      if (commit_valid_q && commit_kill_q) pending_d[commit_id_q] = 1'b0;

      if (wb_valid_q && wb_ready_i) wb_valid_d = 1'b0;

      // Lookup uses the registered table, so a same-cycle kill still lets the
      // result through once without flagging an error.
      if (res_hs) begin
         if (pending_q[x_result_id_i]) begin
            pending_d[x_result_id_i] = 1'b0;
            if (x_result_we_i) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = x_result_rd_i;
               wb_data_d  = x_result_data_i;
               wb_id_d    = x_result_id_i;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         next_id_q      <= '0;
         id_q           <= '0;
         instr_q        <= '0;
         rs1_q          <= '0;
         rs2_q          <= '0;
         accepted_q     <= 1'b0;
         illegal_q      <= 1'b0;
         commit_valid_q <= 1'b0;
         commit_id_q    <= '0;
         commit_kill_q  <= 1'b0;
         pending_q      <= '0;
         wb_valid_q     <= 1'b0;
         wb_rd_q        <= '0;
         wb_data_q      <= '0;
         wb_id_q        <= '0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         next_id_q      <= next_id_d;
         id_q           <= id_d;
         instr_q        <= instr_d;
         rs1_q          <= rs1_d;
         rs2_q          <= rs2_d;
         accepted_q     <= accepted_d;
         illegal_q      <= illegal_d;
         commit_valid_q <= commit_valid_d;
         commit_id_q    <= commit_id_d;
         commit_kill_q  <= commit_kill_d;
         pending_q      <= pending_d;
         wb_valid_q     <= wb_valid_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
         wb_id_q        <= wb_id_d;
         err_q          <= err_d;
      end
   end

   assign req_ready_o      = req_ready;
   assign x_issue_valid_o  = (state_q == S_ISSUE);
   assign x_issue_instr_o  = instr_q;
   assign x_issue_rs1_o    = rs1_q;
   assign x_issue_rs2_o    = rs2_q;
   assign x_issue_id_o     = id_q;
   assign x_commit_valid_o = commit_valid_q;
   assign x_commit_id_o    = commit_id_q;
   assign x_commit_kill_o  = commit_kill_q;
   assign x_result_ready_o = !wb_valid_q || wb_ready_i;
   assign wb_valid_o       = wb_valid_q;
   assign wb_rd_o          = wb_rd_q;
   assign wb_data_o        = wb_data_q;
   assign wb_id_o          = wb_id_q;
   assign illegal_o        = illegal_q;
   assign err_o            = err_q;

endmodule

// File: tb/tb_xif_offload_master.sv
// Directed bench for xif_offload_master: single op, rejection, backpressure,
// outstanding limit with out-of-order results, errors/kill, ID wrap, reset.
module tb_xif_offload_master;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_instr_i = '0, req_rs1_i = '0, req_rs2_i = '0;
   logic        x_issue_valid_o;
   logic        x_issue_ready_i = 1'b0;
   logic [31:0] x_issue_instr_o, x_issue_rs1_o, x_issue_rs2_o;
   logic [3:0]  x_issue_id_o;
   logic        x_issue_accept_i = 1'b0, x_issue_writeback_i = 1'b0;
   logic        commit_valid_i = 1'b0, commit_kill_i = 1'b0;
   logic        x_commit_valid_o;
   logic [3:0]  x_commit_id_o;
   logic        x_commit_kill_o;
   logic        x_result_valid_i = 1'b0;
   logic        x_result_ready_o;
   logic [3:0]  x_result_id_i = '0;
   logic [4:0]  x_result_rd_i = '0;
   logic [31:0] x_result_data_i = '0;
   logic        x_result_we_i = 1'b0;
   logic        wb_valid_o;
   logic        wb_ready_i = 1'b1;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic [3:0]  wb_id_o;
   logic        illegal_o, err_o;

   int checks = 0;
   int failures = 0;

   xif_offload_master #(.ID_WIDTH(4), .MAX_OUTSTANDING(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_instr_i(req_instr_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
      .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
      .x_issue_instr_o(x_issue_instr_o), .x_issue_rs1_o(x_issue_rs1_o),
      .x_issue_rs2_o(x_issue_rs2_o), .x_issue_id_o(x_issue_id_o),
      .x_issue_accept_i(x_issue_accept_i), .x_issue_writeback_i(x_issue_writeback_i),
      .commit_valid_i(commit_valid_i), .commit_kill_i(commit_kill_i),
      .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o),
      .x_commit_kill_o(x_commit_kill_o),
      .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
      .x_result_id_i(x_result_id_i), .x_result_rd_i(x_result_rd_i),
      .x_result_data_i(x_result_data_i), .x_result_we_i(x_result_we_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
      .wb_data_o(wb_data_o), .wb_id_o(wb_id_o),
      .illegal_o(illegal_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Waits (bounded) for req_ready, then performs one request handshake.
   task automatic do_req(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
      int n = 0;
      while (!req_ready_o && n < 20) begin
         tick();
         n++;
      end
      check("req_ready_wait", 64'(req_ready_o), 64'd1);
      req_instr_i = instr;
      req_rs1_i   = rs1;
      req_rs2_i   = rs2;
      req_valid_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
   endtask

   task automatic do_issue(input logic acc, input logic wb);
      x_issue_accept_i    = acc;
      x_issue_writeback_i = wb;
      x_issue_ready_i     = 1'b1;
      tick();
      x_issue_ready_i     = 1'b0;
      check("illegal_pulse", 64'(illegal_o), 64'(!acc));
   endtask

   task automatic do_commit(input logic kill, input logic [3:0] exp_id, input logic exp_kill);
      commit_kill_i  = kill;
      commit_valid_i = 1'b1;
      tick();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      check("commit_valid", 64'(x_commit_valid_o), 64'd1);
      check("commit_id", 64'(x_commit_id_o), 64'(exp_id));
      check("commit_kill", 64'(x_commit_kill_o), 64'(exp_kill));
      check("illegal_one_cycle", 64'(illegal_o), 64'd0);
      tick();
      check("commit_one_cycle", 64'(x_commit_valid_o), 64'd0);
   endtask

   task automatic do_result(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] data,
                            input logic we);
      x_result_id_i    = id;
      x_result_rd_i    = rd;
      x_result_data_i  = data;
      x_result_we_i    = we;
      x_result_valid_i = 1'b1;
      tick();
      x_result_valid_i = 1'b0;
   endtask

   task automatic reset_dut();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      #1;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_req_ready", 64'(req_ready_o), 64'd0);
      check("rst_issue_valid", 64'(x_issue_valid_o), 64'd0);
      check("rst_commit", {62'd0, x_commit_valid_o, x_commit_kill_o}, 64'd0);
      check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
      check("rst_pulses", {62'd0, illegal_o, err_o}, 64'd0);
      check("rst_data", {x_issue_instr_o, 27'd0, wb_rd_o}, 64'd0);
      rst_i = 1'b0;
      #1;
      check("post_rst_req_ready", 64'(req_ready_o), 64'd1);

      // Single accepted op
      do_req(32'h00B50553, 32'h11, 32'h22);
      check("issue_valid", 64'(x_issue_valid_o), 64'd1);
      check("issue_instr", 64'(x_issue_instr_o), 64'h00B50553);
      check("issue_rs", {x_issue_rs1_o, x_issue_rs2_o}, {32'h11, 32'h22});
      check("issue_id0", 64'(x_issue_id_o), 64'd0);
      do_issue(1'b1, 1'b1);
      do_commit(1'b0, 4'd0, 1'b0);
      do_result(4'd0, 5'd10, 32'h3F800000, 1'b1);
      check("wb_valid", 64'(wb_valid_o), 64'd1);
      check("wb_rd", 64'(wb_rd_o), 64'd10);
      check("wb_data", 64'(wb_data_o), 64'h3F800000);
      check("wb_id", 64'(wb_id_o), 64'd0);
      check("no_err", 64'(err_o), 64'd0);
      tick();
      check("wb_cleared", 64'(wb_valid_o), 64'd0);

      // Rejection
      do_req(32'hFFFF_FFFF, 32'h1, 32'h2);
      check("issue_id1", 64'(x_issue_id_o), 64'd1);
      do_issue(1'b0, 1'b1);
      commit_valid_i = 1'b1;
      tick();
      commit_valid_i = 1'b0;
      check("rej_commit_kill", {62'd0, x_commit_valid_o, x_commit_kill_o}, 64'd3);
      check("rej_req_ready", 64'(req_ready_o), 64'd1);
      check("rej_illegal_once", 64'(illegal_o), 64'd0);
      tick();

      // Issue backpressure, then writeback backpressure
      do_req(32'hCAFE_0001, 32'hA, 32'hB);
      for (int i = 0; i < 5; i++) begin
         check("bp_issue_valid", 64'(x_issue_valid_o), 64'd1);
         check("bp_issue_hold", {x_issue_instr_o, 28'd0, x_issue_id_o}, {32'hCAFE_0001, 32'd2});
         tick();
      end
      check("bp_issue_valid6", 64'(x_issue_valid_o), 64'd1);
      do_issue(1'b1, 1'b1);
      check("bp_single_hs", 64'(x_issue_valid_o), 64'd0);
      do_commit(1'b0, 4'd2, 1'b0);
      wb_ready_i = 1'b0;
      do_result(4'd2, 5'd5, 32'h1234_5678, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("bp_wb_valid", 64'(wb_valid_o), 64'd1);
         check("bp_wb_hold", {wb_data_o, 27'd0, wb_rd_o}, {32'h1234_5678, 32'd5});
         check("bp_res_ready", 64'(x_result_ready_o), 64'd0);
         tick();
      end
      wb_ready_i = 1'b1;
      #1;
      check("bp_res_ready_rel", 64'(x_result_ready_o), 64'd1);
      tick();
      check("bp_wb_done", 64'(wb_valid_o), 64'd0);

      // Outstanding limit and out-of-order results
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         do_req(32'h100 + 32'(i), 32'd0, 32'd0);
         check("lim_issue_id", 64'(x_issue_id_o), 64'(i));
         do_issue(1'b1, 1'b1);
         commit_valid_i = 1'b1;
         tick();
         commit_valid_i = 1'b0;
      end
      check("lim_req_ready0", 64'(req_ready_o), 64'd0);
      tick();
      check("lim_req_ready0b", 64'(req_ready_o), 64'd0);
      do_result(4'd2, 5'd3, 32'h202, 1'b1);
      check("lim_req_ready1", 64'(req_ready_o), 64'd1);
      check("ooo_wb2", {wb_valid_o, 27'd0, wb_id_o, wb_data_o}, {1'b1, 27'd0, 4'd2, 32'h202});
      do_result(4'd3, 5'd4, 32'h303, 1'b1);
      check("ooo_wb3", {wb_valid_o, 27'd0, wb_id_o, wb_data_o}, {1'b1, 27'd0, 4'd3, 32'h303});
      do_result(4'd0, 5'd1, 32'h000, 1'b1);
      check("ooo_wb0", {wb_valid_o, 27'd0, wb_id_o, wb_data_o}, {1'b1, 27'd0, 4'd0, 32'h000});
      do_result(4'd1, 5'd2, 32'h101, 1'b1);
      check("ooo_wb1", {wb_valid_o, 27'd0, wb_id_o, wb_data_o}, {1'b1, 27'd0, 4'd1, 32'h101});
      check("ooo_rd1", 64'(wb_rd_o), 64'd2);
      check("ooo_no_err", 64'(err_o), 64'd0);
      tick();

      // Errors and kill
      do_result(4'd7, 5'd7, 32'h777, 1'b1);
      check("err_unexp", 64'(err_o), 64'd1);
      check("err_no_wb", 64'(wb_valid_o), 64'd0);
      tick();
      check("err_one_cycle", 64'(err_o), 64'd0);
      do_req(32'h44, 32'd0, 32'd0);
      check("kill_issue_id", 64'(x_issue_id_o), 64'd4);
      do_issue(1'b1, 1'b1);
      do_commit(1'b1, 4'd4, 1'b1);
      do_result(4'd4, 5'd9, 32'h999, 1'b1);
      check("kill_late_err", 64'(err_o), 64'd1);
      check("kill_late_no_wb", 64'(wb_valid_o), 64'd0);

      // Kill and result for the same ID in the same cycle
      do_req(32'h55, 32'd0, 32'd0);
      do_issue(1'b1, 1'b1);
      commit_kill_i  = 1'b1;
      commit_valid_i = 1'b1;
      tick();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
      check("same_kill_vis", {62'd0, x_commit_valid_o, x_commit_kill_o}, 64'd3);
      do_result(4'd5, 5'd11, 32'h555, 1'b1);
      check("same_no_err", 64'(err_o), 64'd0);
      check("same_wb", {wb_valid_o, 27'd0, wb_id_o}, {1'b1, 27'd0, 4'd5});
      do_result(4'd5, 5'd11, 32'h556, 1'b1);
      check("same_cleared_once", 64'(err_o), 64'd1);
      tick();

      // ID wrap and reset during ISSUE
      reset_dut();
      for (int i = 0; i < 16; i++) begin
         do_req(32'(i), 32'd0, 32'd0);
         check("wrap_id", 64'(x_issue_id_o), 64'(i));
         do_issue(1'b1, 1'b0);
         commit_valid_i = 1'b1;
         tick();
         commit_valid_i = 1'b0;
      end
      do_req(32'hDEAD_BEEF, 32'h5, 32'h6);
      check("wrap_id17", 64'(x_issue_id_o), 64'd0);
      check("wrap_issue_valid", 64'(x_issue_valid_o), 64'd1);
      rst_i = 1'b1;
      tick();
      check("midrst_issue", {63'd0, x_issue_valid_o}, 64'd0);
      check("midrst_data", {x_issue_instr_o, x_issue_rs1_o}, 64'd0);
      check("midrst_ready", 64'(req_ready_o), 64'd0);
      check("midrst_out", {60'd0, wb_valid_o, x_commit_valid_o, illegal_o, err_o}, 64'd0);
      rst_i = 1'b0;
      #1;
      do_req(32'h77, 32'd0, 32'd0);
      check("midrst_next_id", 64'(x_issue_id_o), 64'd0);
      tick();
      check("midrst_no_commit", 64'(x_commit_valid_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded limit");
      $fatal(1, "timeout");
   end

endmodule
